// File: rtl/add_sub_seq_pkg.sv
// Shared types and helpers for the sequential chunked adder/subtractor.
// Holds the FSM state encoding and a minimum-one clog2 used for counter sizing.
package add_sub_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to index n items, never less than one so a single-chunk build still has a counter.
  function automatic int clog2Min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/add_sub_seq_chunk.sv
// Combinational CHUNK-bit ripple of full-adder cells.
// Also exposes the carry into the top bit so the caller can derive signed overflow.
module add_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o,
  output logic             cTop_o
);

  logic [CHUNK:0] carry;

  assign carry[0] = c_i;

  for (genvar i = 0; i < CHUNK; i++) begin : gCell
    assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o    = carry[CHUNK];
  assign cTop_o = carry[CHUNK-1];

endmodule

// File: rtl/add_sub_seq.sv
// Multi-cycle two's-complement adder/subtractor: one CHUNK-bit slice per clock,
// carry registered between slices, valid/ready handshakes on both sides.
module add_sub_seq
  import add_sub_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCHUNK     = WIDTH / SAFE_CHUNK;
  localparam int CW         = clog2Min1(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (CHUNK < 1) begin : gBadChunk
    $fatal(1, "add_sub_seq: CHUNK must be at least 1");
  end else if ((WIDTH % SAFE_CHUNK) != 0) begin : gBadWidth
    $fatal(1, "add_sub_seq: WIDTH must be a multiple of CHUNK");
  end

  state_e                               state_q, state_d;
  logic [NCHUNK-1:0][SAFE_CHUNK-1:0]    opA_q, opA_d;
  logic [NCHUNK-1:0][SAFE_CHUNK-1:0]    opB_q, opB_d;
  logic [NCHUNK-1:0][SAFE_CHUNK-1:0]    sum_q, sum_d;
  logic                                 carry_q, carry_d;
  logic [CW-1:0]                        cnt_q, cnt_d;
  logic                                 cOut_q, cOut_d;
  logic                                 ovf_q, ovf_d;

  logic [SAFE_CHUNK-1:0] sliceSum;
  logic                  sliceCout;
  logic                  sliceCTop;

  // The slice under work is picked by the counter; operands stay put for the whole operation.
  add_chunk #(
    .CHUNK (SAFE_CHUNK)
  ) uChunk (
    .a_i    (opA_q[cnt_q]),
    .b_i    (opB_q[cnt_q]),
    .c_i    (carry_q),
    .s_o    (sliceSum),
    .c_o    (sliceCout),
    .cTop_o (sliceCTop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cOut_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cOut_q  <= cOut_d;
      ovf_q   <= ovf_d;
    end
  end

  // Subtraction is folded in at accept time as a + ~b + 1, so BUSY only ever adds.
  always_comb begin
    state_d   = state_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    cOut_d    = cOut_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          opA_d   = a;
          opB_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : c_in;
          sum_d   = '0;
          cnt_d   = '0;
          cOut_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d[cnt_q] = sliceSum;
        carry_d      = sliceCout;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cOut_d  = sliceCout;
          ovf_d   = sliceCout ^ sliceCTop;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sum   = sum_q;
  assign c_out = cOut_q;
  assign ovf   = ovf_q;
  assign zero  = out_valid && (sum_q == '0);

endmodule

// File: tb/tb_add_sub_seq.sv
// Randomised scoreboard bench for add_sub_seq: an 8-bit-chunk build and a single-chunk build,
// checked against plain integer arithmetic.
module tb_add_sub_seq;

  localparam int W = 32;

  typedef struct {
    int          which;
    logic [31:0] sum;
    logic        cOut;
    logic        ovf;
    longint      acceptEdge;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [W-1:0]     a, b;
  logic             cIn, subOp;
  logic [1:0]       inValid, inReady, outValid, outReady, cOut, ovfO, zeroO;
  logic [1:0][W-1:0] sumO;

  exp_t   expQ[$];
  longint edgeCount;
  int     stallMode;
  int     total, bad;

  logic [1:0]        popped, haveLast, heldC, heldO;
  logic [1:0][W-1:0] heldSum;

  add_sub_seq #(.WIDTH(W), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .a(a), .b(b), .c_in(cIn), .sub(subOp),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .sum(sumO[0]),
    .c_out(cOut[0]), .ovf(ovfO[0]), .zero(zeroO[0])
  );

  add_sub_seq #(.WIDTH(W), .CHUNK(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .a(a), .b(b), .c_in(cIn), .sub(subOp),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .sum(sumO[1]),
    .c_out(cOut[1]), .ovf(ovfO[1]), .zero(zeroO[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    edgeCount = 0;
    forever begin
      @(posedge clk);
      edgeCount++;
    end
  end

  // Consumer side: always ready, random stalls, or held off completely.
  initial begin
    outReady = 2'b11;
    forever begin
      @(negedge clk);
      case (stallMode)
        1:       outReady = 2'($urandom_range(0, 3));
        2:       outReady = 2'b00;
        default: outReady = 2'b11;
      endcase
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", name, act, expv, edgeCount);
    end
  endtask

  // Reference: true signed/unsigned integer results, no knowledge of slicing.
  function automatic exp_t refModel(input logic [31:0] av, input logic [31:0] bv,
                                    input logic ci, input logic s);
    exp_t   e;
    longint sa, sb, ua, ub, r, u;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = longint'(av);
    ub = longint'(bv);
    if (s) begin
      r      = sa - sb;
      e.cOut = (ua >= ub);
      e.sum  = av - bv;
    end else begin
      r      = sa + sb + longint'(ci);
      u      = ua + ub + longint'(ci);
      e.cOut = (u >= 64'sd4294967296);
      e.sum  = av + bv + {31'd0, ci};
    end
    e.ovf        = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.which      = 0;
    e.acceptEdge = 0;
    return e;
  endfunction

  task automatic applyStimulus(input int which, input logic [31:0] av, input logic [31:0] bv,
                               input logic ci, input logic s);
    exp_t e;
    int   n;
    @(negedge clk);
    a = av; b = bv; cIn = ci; subOp = s;
    inValid[which] = 1'b1;
    n = 0;
    while (!inReady[which] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!inReady[which]) begin
      checkOutput("accept_timeout", 64'(inReady[which]), 64'd1);
    end else begin
      e            = refModel(av, bv, ci, s);
      e.which      = which;
      e.acceptEdge = edgeCount + 1;
      expQ.push_back(e);
    end
    @(negedge clk);
    inValid[which] = 1'b0;
    a = $urandom; b = $urandom; cIn = 1'($urandom); subOp = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || outValid != 2'b00) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) checkOutput("drain_timeout", 64'(expQ.size()), 64'd0);
  endtask

  task automatic resetChecks();
    for (int d = 0; d < 2; d++) begin
      checkOutput("rst_out_valid", 64'(outValid[d]), 64'd0);
      checkOutput("rst_in_ready", 64'(inReady[d]), 64'd1);
      checkOutput("rst_sum", 64'(sumO[d]), 64'd0);
      checkOutput("rst_c_out", 64'(cOut[d]), 64'd0);
      checkOutput("rst_ovf", 64'(ovfO[d]), 64'd0);
      checkOutput("rst_zero", 64'(zeroO[d]), 64'd0);
    end
  endtask

  // Monitor: pops the oldest expectation for a DUT when its result first appears,
  // then insists the result stays frozen while held and after returning to idle.
  initial begin : monitor
    exp_t e;
    int   idx;
    popped   = '0;
    haveLast = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst_n !== 1'b1) begin
          popped[d]   = 1'b0;
          haveLast[d] = 1'b0;
        end else if (outValid[d]) begin
          if (!popped[d]) begin
            idx = -1;
            foreach (expQ[i]) if (idx < 0 && expQ[i].which == d) idx = i;
            if (idx < 0) begin
              checkOutput("unexpected_result", 64'(outValid[d]), 64'd0);
            end else begin
              e = expQ[idx];
              expQ.delete(idx);
              checkOutput("sum", 64'(sumO[d]), 64'(e.sum));
              checkOutput("c_out", 64'(cOut[d]), 64'(e.cOut));
              checkOutput("ovf", 64'(ovfO[d]), 64'(e.ovf));
              checkOutput("zero", 64'(zeroO[d]), 64'(e.sum == 32'd0));
              checkOutput("latency", 64'(edgeCount - e.acceptEdge), (d == 0) ? 64'd4 : 64'd1);
            end
            checkOutput("done_in_ready", 64'(inReady[d]), 64'd0);
            popped[d]   = 1'b1;
            haveLast[d] = 1'b1;
            heldSum[d]  = sumO[d];
            heldC[d]    = cOut[d];
            heldO[d]    = ovfO[d];
          end else begin
            checkOutput("hold_sum", 64'(sumO[d]), 64'(heldSum[d]));
            checkOutput("hold_c_out", 64'(cOut[d]), 64'(heldC[d]));
            checkOutput("hold_ovf", 64'(ovfO[d]), 64'(heldO[d]));
            checkOutput("hold_in_ready", 64'(inReady[d]), 64'd0);
          end
        end else begin
          popped[d] = 1'b0;
          checkOutput("zero_qualified", 64'(zeroO[d]), 64'd0);
          if (haveLast[d] && inReady[d]) begin
            checkOutput("idle_sum_kept", 64'(sumO[d]), 64'(heldSum[d]));
            checkOutput("idle_c_out_kept", 64'(cOut[d]), 64'(heldC[d]));
            checkOutput("idle_ovf_kept", 64'(ovfO[d]), 64'(heldO[d]));
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] av, bv;
    int          which, n;
    total = 0; bad = 0; stallMode = 0;
    rst_n = 1'b0;
    inValid = '0;
    a = '0; b = '0; cIn = 1'b0; subOp = 1'b0;
    repeat (2) @(negedge clk);
    resetChecks();
    rst_n = 1'b1;

    applyStimulus(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    applyStimulus(0, 32'd5, 32'd7, 1'b1, 1'b1);
    applyStimulus(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    applyStimulus(0, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0);
    drain();

    $display("[TB] backpressure with new operands offered while holding a result");
    stallMode = 2;
    applyStimulus(0, 32'hA5A5_0001, 32'h0000_00FF, 1'b0, 1'b0);
    fork
      applyStimulus(0, 32'h1111_2222, 32'h3333_4444, 1'b1, 1'b0);
      begin : holdCheck
        n = 0;
        while (!outValid[0] && n < 50) begin
          @(negedge clk);
          n++;
        end
        if (!outValid[0]) checkOutput("bp_result_timeout", 64'(outValid[0]), 64'd1);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checkOutput("bp_in_ready", 64'(inReady[0]), 64'd0);
          checkOutput("bp_out_valid", 64'(outValid[0]), 64'd1);
        end
        stallMode = 0;
      end
    join
    drain();

    $display("[TB] reset in the middle of an operation");
    applyStimulus(0, $urandom, $urandom, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    for (int i = expQ.size() - 1; i >= 0; i--) if (expQ[i].which == 0) expQ.delete(i);
    @(negedge clk);
    resetChecks();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    resetChecks();
    applyStimulus(0, 32'd3, 32'd4, 1'b0, 1'b0);
    drain();

    $display("[TB] single-chunk build");
    applyStimulus(1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    applyStimulus(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    drain();

    $display("[TB] randomised traffic with consumer stalls");
    stallMode = 1;
    for (int t = 0; t < 40; t++) begin
      which = int'($urandom_range(0, 1));
      av = $urandom;
      bv = $urandom;
      case ($urandom_range(0, 5))
        0: bv = av;
        1: bv = ~av;
        2: av = 32'h7FFF_FFFF;
        3: av = 32'h8000_0000;
        default: ;
      endcase
      applyStimulus(which, av, bv, 1'($urandom), 1'($urandom));
    end
    stallMode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_sub_seq.md
Name: add_sub_seq

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor with valid/ready handshakes on input and output.
- Each cycle it processes one CHUNK-bit slice using a ripple chain of the team's full-adder cell, and registers the carry between slices.
- Trades latency for area against the flat N-bit ripple adder.
- Used as the arithmetic engine behind the ALU when WIDTH is large. Adds subtract mode, overflow/zero flags and flow control.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits processed per cycle; CHUNK == WIDTH gives a single-cycle compute.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands presented
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
c_in  input  1  carry-in for add; ignored when sub=1
sub  input  1  0: a+b+c_in; 1: a-b (a + ~b + 1)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
c_out  output  1  carry out of MSB (for sub: 1 = no borrow)
ovf  output  1  signed overflow
zero  output  1  sum == 0

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE; in_ready=1; out_valid=0; sum=0, c_out=0, ovf=0, zero=0; chunk counter=0; carry register=0.
- NCHUNK = WIDTH/CHUNK. Counter width = clog2(NCHUNK), minimum 1.
- IDLE state:
  - in_ready=1.
  - On in_valid&&in_ready: latch a; latch b, or ~b when sub=1; carry register = sub ? 1 : c_in.
  - Clear sum, the counter and the flags; go to BUSY.
- BUSY state:
  - in_ready=0 and out_valid=0.
  - Each cycle, slice k = counter: sum[k*CHUNK +: CHUNK] = a_slice + b_slice + carry.
  - Carry register takes the slice carry-out; counter increments.
  - On the last slice (k = NCHUNK-1): capture c_out = slice carry-out and ovf = (carry into MSB) XOR (carry out of MSB). Go to DONE.
- Latency: out_valid rises exactly NCHUNK clock edges after the accepting edge (4 for the defaults).
- zero is combinational on the registered sum, qualified by out_valid: 0 when out_valid=0.
- DONE state:
  - out_valid=1, in_ready=0.
  - sum, c_out, ovf and zero are held stable while out_ready=0, for any number of cycles.
  - On out_valid&&out_ready: go to IDLE; out_valid drops the next cycle. sum and the flags keep their values until the next accept.
- No overlap: a new operand is never accepted in BUSY or DONE. in_valid during those states is ignored, not queued.
- Operands changing after the accept edge have no effect.
- Reset asserted in any state aborts the operation immediately and forces the reset values. The first accept after reset release behaves normally.
- Wrap-around: sum is modulo 2^WIDTH. Carry/overflow are reported only through c_out and ovf.
- Elaboration: WIDTH % CHUNK != 0 or CHUNK < 1 is a fatal elaboration error.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and a clog2 helper function.
- Sub-module add_chunk #(CHUNK): combinational CHUNK-bit ripple of full-adder cells.
  - Outputs: slice sum, carry-out, and carry into its top bit (needed for ovf).
- Top level holds the FSM, the operand/result registers and the counter.

Test Plan:
1. WIDTH=32, CHUNK=8, sub=0, a=0xFFFFFFFF, b=0x00000001, c_in=0 -> sum=0x00000000, c_out=1, ovf=0, zero=1. out_valid rises exactly 4 edges after accept.
2. sub=1, a=5, b=7, c_in=1 (ignored) -> sum=0xFFFFFFFE, c_out=0, ovf=0, zero=0.
3. sub=0, a=0x7FFFFFFF, b=1, c_in=0 -> sum=0x80000000, ovf=1, c_out=0. Then a=0x12345678, b=0x0F0F0F0F, c_in=1 -> sum=0x21436588, c_out=0, ovf=0.
4. Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands -> outputs stable, in_ready=0, new operands not taken. After out_ready=1, IDLE accepts them and the next result is correct.
5. Assert rst_n=0 two cycles into BUSY -> out_valid=0, sum=0, flags=0, in_ready=1 after release. Next op 3+4 -> sum=7 after 4 edges.
6. CHUNK=32 build: sub=1, a=0x80000000, b=1 -> sum=0x7FFFFFFF, c_out=1, ovf=1, out_valid one edge after accept.
